// File: rtl/paddle_mover_pkg.sv
// rtl/paddle_mover_pkg.sv - rink geometry, paddle timing constants and step/clamp helpers
package paddle_mover_pkg;

   localparam int MID_X        = 464;
   localparam int X_LO         = 234;
   localparam int X_HI         = 694;
   localparam int Y_LO         = 111;
   localparam int Y_HI         = 431;
   localparam int PAD_R        = 16;
   localparam int HOME1_X      = 300;
   localparam int HOME2_X      = 628;
   localparam int HOME_Y       = 271;
   localparam int SPD_MIN      = 2;
   localparam int SPD_MAX      = 6;
   localparam int RAMP_TICKS   = 8;
   localparam int FREEZE_TICKS = 30;

   localparam int X1_MIN = X_LO + PAD_R;
   localparam int X1_MAX = MID_X - PAD_R;
   localparam int X2_MIN = MID_X + PAD_R;
   localparam int X2_MAX = X_HI - PAD_R;
   localparam logic signed [10:0] Y_MIN_S = 11'(Y_LO + PAD_R);
   localparam logic signed [10:0] Y_MAX_S = 11'(Y_HI - PAD_R);

   typedef enum logic {
      PLAY   = 1'b0,
      FREEZE = 1'b1
   } state_e;

   // +1 when only pos is pressed, -1 when only neg is pressed, else 0
   function automatic logic signed [1:0] axis_dir(input logic pos, input logic neg);
      logic signed [1:0] d;
      d = 2'sd0;
      if (pos && !neg) d = 2'sd1;
      else if (neg && !pos) d = -2'sd1;
      return d;
   endfunction

   function automatic logic [9:0] step_clamp(input logic [9:0] cur,
                                              input logic signed [1:0] dir,
                                              input logic [2:0] spd,
                                              input logic signed [10:0] lo,
                                              input logic signed [10:0] hi);
      logic signed [10:0] step;
      logic signed [10:0] nxt;
      logic [9:0]         res;
      step = 11'sd0;
      if (dir == 2'sd1) step = $signed({8'd0, spd});
      else if (dir == -2'sd1) step = -$signed({8'd0, spd});
      nxt = $signed({1'b0, cur}) + step;
      if (nxt < lo) res = lo[9:0];
      else if (nxt > hi) res = hi[9:0];
      else res = nxt[9:0];
      return res;
   endfunction

endpackage

// File: rtl/paddle_mover_if.sv
// rtl/paddle_mover_if.sv - button/goal inputs and paddle position outputs of the paddle mover
interface paddle_mover_if;
   logic       prev_clk_cursor;
   logic       clk_cursor;
   logic       btn1_up, btn1_dn, btn1_lt, btn1_rt;
   logic       btn2_up, btn2_dn, btn2_lt, btn2_rt;
   logic       collide1, collide2;
   logic [9:0] ball1_x, ball1_y;
   logic [9:0] ball2_x, ball2_y;
   logic       frozen;

   modport master (
      output prev_clk_cursor, clk_cursor,
      output btn1_up, btn1_dn, btn1_lt, btn1_rt,
      output btn2_up, btn2_dn, btn2_lt, btn2_rt,
      output collide1, collide2,
      input  ball1_x, ball1_y, ball2_x, ball2_y, frozen
   );

   modport slave (
      input  prev_clk_cursor, clk_cursor,
      input  btn1_up, btn1_dn, btn1_lt, btn1_rt,
      input  btn2_up, btn2_dn, btn2_lt, btn2_rt,
      input  collide1, collide2,
      output ball1_x, ball1_y, ball2_x, ball2_y, frozen
   );
endinterface

// File: rtl/paddle_mover_unit.sv
// rtl/paddle_mover_unit.sv - one paddle: button synchronisers, axis decode, speed ramp, clamped position
module paddle_unit
   import paddle_mover_pkg::*;
#(
   parameter int XMIN   = X1_MIN,
   parameter int XMAX   = X1_MAX,
   parameter int HOME_X = HOME1_X
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       tick_i,
   input  logic       home_load_i,
   input  logic       move_en_i,
   input  logic       btn_up_i,
   input  logic       btn_dn_i,
   input  logic       btn_lt_i,
   input  logic       btn_rt_i,
   output logic [9:0] x_o,
   output logic [9:0] y_o
);

   localparam logic signed [10:0] XMIN_S    = 11'(XMIN);
   localparam logic signed [10:0] XMAX_S    = 11'(XMAX);
   localparam logic [9:0]         HOME_X_C  = 10'(HOME_X);
   localparam logic [9:0]         HOME_Y_C  = 10'(HOME_Y);
   localparam logic [2:0]         SPD_MIN_C = 3'(SPD_MIN);
   localparam logic [2:0]         SPD_MAX_C = 3'(SPD_MAX);
   localparam logic [2:0]         HOLD_LAST = 3'(RAMP_TICKS - 1);

   // bit order {up, dn, lt, rt}
   logic [3:0] sync1_q, sync2_q;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic [2:0] spd_q, spd_d;
   logic [2:0] hold_q, hold_d;
   logic signed [1:0] dir_x, dir_y;
   logic held;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1_q <= 4'd0;
         sync2_q <= 4'd0;
      end else begin
         sync1_q <= {btn_up_i, btn_dn_i, btn_lt_i, btn_rt_i};
         sync2_q <= sync1_q;
      end
   end

   assign dir_x = axis_dir(sync2_q[0], sync2_q[1]);
   assign dir_y = axis_dir(sync2_q[2], sync2_q[3]);
   assign held  = (dir_x != 2'sd0) || (dir_y != 2'sd0);

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      spd_d  = spd_q;
      hold_d = hold_q;
      if (tick_i) begin
         if (home_load_i) begin
            x_d    = HOME_X_C;
            y_d    = HOME_Y_C;
            spd_d  = SPD_MIN_C;
            hold_d = 3'd0;
         end else if (move_en_i) begin
            if (held) begin
               // move with the speed in force before this tick, then advance the ramp
               x_d = step_clamp(x_q, dir_x, spd_q, XMIN_S, XMAX_S);
               y_d = step_clamp(y_q, dir_y, spd_q, Y_MIN_S, Y_MAX_S);
               if (hold_q == HOLD_LAST) begin
                  hold_d = 3'd0;
                  if (spd_q < SPD_MAX_C) spd_d = spd_q + 3'd1;
               end else begin
                  hold_d = hold_q + 3'd1;
               end
            end else begin
               spd_d  = SPD_MIN_C;
               hold_d = 3'd0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         x_q    <= HOME_X_C;
         y_q    <= HOME_Y_C;
         spd_q  <= SPD_MIN_C;
         hold_q <= 3'd0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         spd_q  <= spd_d;
         hold_q <= hold_d;
      end
   end

   assign x_o = x_q;
   assign y_o = y_q;

endmodule

// File: rtl/paddle_mover.sv
// rtl/paddle_mover.sv - top: game tick detect, PLAY/FREEZE state machine, two paddle units
module paddle_mover
   import paddle_mover_pkg::*;
(
   input logic          clk,
   input logic          clr,
   paddle_mover_if.slave bus
);

   localparam logic [4:0] FREEZE_LAST = 5'(FREEZE_TICKS - 1);

   state_e     state_q, state_d;
   logic [4:0] frz_cnt_q, frz_cnt_d;
   logic       tick, goal, home_load, move_en;

   assign tick = !bus.prev_clk_cursor && bus.clk_cursor;
   assign goal = bus.collide1 || bus.collide2;

   always_comb begin
      state_d   = state_q;
      frz_cnt_d = frz_cnt_q;
      home_load = 1'b0;
      if (tick) begin
         case (state_q)
            PLAY: begin
               if (goal) begin
                  home_load = 1'b1;
                  frz_cnt_d = 5'd0;
                  state_d   = FREEZE;
               end
            end
            FREEZE: begin
               if (goal) begin
                  frz_cnt_d = 5'd0;
               end else if (frz_cnt_q == FREEZE_LAST) begin
                  frz_cnt_d = 5'd0;
                  state_d   = PLAY;
               end else begin
                  frz_cnt_d = frz_cnt_q + 5'd1;
               end
            end
            default: state_d = PLAY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= PLAY;
         frz_cnt_q <= 5'd0;
      end else begin
         state_q   <= state_d;
         frz_cnt_q <= frz_cnt_d;
      end
   end

   assign move_en    = (state_q == PLAY);
   assign bus.frozen = (state_q == FREEZE);

   paddle_unit #(.XMIN(X1_MIN), .XMAX(X1_MAX), .HOME_X(HOME1_X)) u_pad1 (
      .clk        (clk),
      .clr        (clr),
      .tick_i     (tick),
      .home_load_i(home_load),
      .move_en_i  (move_en),
      .btn_up_i   (bus.btn1_up),
      .btn_dn_i   (bus.btn1_dn),
      .btn_lt_i   (bus.btn1_lt),
      .btn_rt_i   (bus.btn1_rt),
      .x_o        (bus.ball1_x),
      .y_o        (bus.ball1_y)
   );

   paddle_unit #(.XMIN(X2_MIN), .XMAX(X2_MAX), .HOME_X(HOME2_X)) u_pad2 (
      .clk        (clk),
      .clr        (clr),
      .tick_i     (tick),
      .home_load_i(home_load),
      .move_en_i  (move_en),
      .btn_up_i   (bus.btn2_up),
      .btn_dn_i   (bus.btn2_dn),
      .btn_lt_i   (bus.btn2_lt),
      .btn_rt_i   (bus.btn2_rt),
      .x_o        (bus.ball2_x),
      .y_o        (bus.ball2_y)
   );

endmodule

// File: tb/tb_paddle_mover.sv
// tb/tb_paddle_mover.sv - directed self-checking bench for paddle_mover
module tb_paddle_mover;

   logic clk;
   logic clr;
   int   n_cmp;
   int   n_bad;

   paddle_mover_if bus();

   paddle_mover dut (
      .clk(clk),
      .clr(clr),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // b = {up, dn, lt, rt}
   task automatic set_btns(input logic [3:0] b1, input logic [3:0] b2);
      {bus.btn1_up, bus.btn1_dn, bus.btn1_lt, bus.btn1_rt} = b1;
      {bus.btn2_up, bus.btn2_dn, bus.btn2_lt, bus.btn2_rt} = b2;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_tick();
      @(negedge clk);
      bus.prev_clk_cursor = 1'b0;
      bus.clk_cursor      = 1'b1;
      @(negedge clk);
      bus.prev_clk_cursor = 1'b1;
      bus.clk_cursor      = 1'b0;
      @(negedge clk);
      bus.prev_clk_cursor = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({bus.ball1_x, bus.ball1_y, bus.ball2_x, bus.ball2_y, bus.frozen} !==
          {10'd300, 10'd271, 10'd628, 10'd271, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_state: got b1=(%0d,%0d) b2=(%0d,%0d) frz=%0b want (300,271) (628,271) 0",
                  bus.ball1_x, bus.ball1_y, bus.ball2_x, bus.ball2_y, bus.frozen);
      end
   endtask

   task automatic test_ramp();
      int exp_x;
      exp_x = 300;
      set_btns(4'b0001, 4'b0000);
      for (int i = 1; i <= 20; i++) begin
         do_tick();
         exp_x += (i <= 8) ? 2 : ((i <= 16) ? 3 : 4);
         n_cmp++;
         if (bus.ball1_x !== 10'(exp_x) || bus.ball1_y !== 10'd271) begin
            n_bad++;
            $display("FAIL ramp_tick%0d: got (%0d,%0d) want (%0d,271)", i, bus.ball1_x, bus.ball1_y, exp_x);
         end
      end
      set_btns(4'b0000, 4'b0000);
      do_tick();
      n_cmp++;
      if (bus.ball1_x !== 10'd356) begin
         n_bad++;
         $display("FAIL ramp_release: got %0d want 356", bus.ball1_x);
      end
      set_btns(4'b0001, 4'b0000);
      do_tick();
      n_cmp++;
      if (bus.ball1_x !== 10'd358) begin
         n_bad++;
         $display("FAIL ramp_restart: got %0d want 358", bus.ball1_x);
      end
      set_btns(4'b0000, 4'b0000);
      do_tick();
   endtask

   task automatic test_opposite();
      set_btns(4'b0111, 4'b0000);
      repeat (9) do_tick();
      n_cmp++;
      if (bus.ball1_x !== 10'd358 || bus.ball1_y !== 10'd290) begin
         n_bad++;
         $display("FAIL opposite: got (%0d,%0d) want (358,290)", bus.ball1_x, bus.ball1_y);
      end
      set_btns(4'b0000, 4'b0000);
      do_tick();
   endtask

   task automatic test_clamp();
      set_btns(4'b0001, 4'b0000);
      repeat (100) do_tick();
      n_cmp++;
      if (bus.ball1_x !== 10'd448 || bus.ball1_y !== 10'd290) begin
         n_bad++;
         $display("FAIL clamp_p1_right: got (%0d,%0d) want (448,290)", bus.ball1_x, bus.ball1_y);
      end
      set_btns(4'b0000, 4'b0010);
      do_tick();
      repeat (99) do_tick();
      n_cmp++;
      if (bus.ball2_x !== 10'd480 || bus.ball2_y !== 10'd271) begin
         n_bad++;
         $display("FAIL clamp_p2_left: got (%0d,%0d) want (480,271)", bus.ball2_x, bus.ball2_y);
      end
      set_btns(4'b0000, 4'b1000);
      for (int i = 0; i < 100; i++) begin
         do_tick();
         n_cmp++;
         if (bus.ball2_y < 10'd127 || bus.ball2_y > 10'd271) begin
            n_bad++;
            $display("FAIL clamp_p2_up_range: got %0d want 127..271", bus.ball2_y);
         end
      end
      n_cmp++;
      if (bus.ball2_y !== 10'd127 || bus.ball2_x !== 10'd480) begin
         n_bad++;
         $display("FAIL clamp_p2_up: got (%0d,%0d) want (480,127)", bus.ball2_x, bus.ball2_y);
      end
      set_btns(4'b0000, 4'b0000);
      do_tick();
   endtask

   task automatic test_goal_freeze();
      bus.collide2 = 1'b1;
      do_tick();
      bus.collide2 = 1'b0;
      n_cmp++;
      if ({bus.ball1_x, bus.ball1_y, bus.ball2_x, bus.ball2_y, bus.frozen} !==
          {10'd300, 10'd271, 10'd628, 10'd271, 1'b1}) begin
         n_bad++;
         $display("FAIL goal_entry: got b1=(%0d,%0d) b2=(%0d,%0d) frz=%0b want (300,271) (628,271) 1",
                  bus.ball1_x, bus.ball1_y, bus.ball2_x, bus.ball2_y, bus.frozen);
      end
      set_btns(4'b0001, 4'b0100);
      for (int i = 1; i <= 29; i++) begin
         do_tick();
         n_cmp++;
         if (bus.frozen !== 1'b1 || bus.ball1_x !== 10'd300 || bus.ball2_y !== 10'd271) begin
            n_bad++;
            $display("FAIL freeze_hold%0d: got frz=%0b x1=%0d y2=%0d want 1 300 271",
                     i, bus.frozen, bus.ball1_x, bus.ball2_y);
         end
      end
      do_tick();
      n_cmp++;
      if (bus.frozen !== 1'b0 || bus.ball1_x !== 10'd300 || bus.ball2_y !== 10'd271) begin
         n_bad++;
         $display("FAIL freeze_exit: got frz=%0b x1=%0d y2=%0d want 0 300 271",
                  bus.frozen, bus.ball1_x, bus.ball2_y);
      end
      do_tick();
      n_cmp++;
      if (bus.ball1_x !== 10'd302 || bus.ball2_y !== 10'd273 || bus.ball2_x !== 10'd628) begin
         n_bad++;
         $display("FAIL resume_move: got x1=%0d b2=(%0d,%0d) want 302 (628,273)",
                  bus.ball1_x, bus.ball2_x, bus.ball2_y);
      end
      set_btns(4'b0000, 4'b0000);
      do_tick();
   endtask

   task automatic test_freeze_restart();
      bus.collide1 = 1'b1;
      do_tick();
      bus.collide1 = 1'b0;
      n_cmp++;
      if (bus.frozen !== 1'b1 || bus.ball1_x !== 10'd300 || bus.ball2_y !== 10'd271) begin
         n_bad++;
         $display("FAIL restart_entry: got frz=%0b x1=%0d y2=%0d want 1 300 271",
                  bus.frozen, bus.ball1_x, bus.ball2_y);
      end
      repeat (9) do_tick();
      bus.collide1 = 1'b1;
      do_tick();
      bus.collide1 = 1'b0;
      for (int i = 1; i <= 29; i++) begin
         do_tick();
         n_cmp++;
         if (bus.frozen !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_hold%0d: got frz=%0b want 1", i, bus.frozen);
         end
      end
      do_tick();
      n_cmp++;
      if (bus.frozen !== 1'b0) begin
         n_bad++;
         $display("FAIL restart_exit: got frz=%0b want 0", bus.frozen);
      end
      // sub-cycle pulses that never straddle a rising clk edge
      @(posedge clk);
      #2 bus.btn1_up = 1'b1; bus.btn2_rt = 1'b1;
      #4 bus.btn1_up = 1'b0; bus.btn2_rt = 1'b0;
      repeat (3) @(negedge clk);
      do_tick();
      n_cmp++;
      if (bus.ball1_y !== 10'd271 || bus.ball2_x !== 10'd628) begin
         n_bad++;
         $display("FAIL glitch: got y1=%0d x2=%0d want 271 628", bus.ball1_y, bus.ball2_x);
      end
   endtask

   task automatic test_reset_mid_run();
      set_btns(4'b0001, 4'b0000);
      repeat (3) do_tick();
      n_cmp++;
      if (bus.ball1_x !== 10'd306) begin
         n_bad++;
         $display("FAIL pre_reset_move: got %0d want 306", bus.ball1_x);
      end
      @(posedge clk);
      #3 clr = 1'b1;
      #1 test_reset();
      @(negedge clk);
      clr = 1'b0;
      set_btns(4'b0000, 4'b0000);
      bus.collide2 = 1'b1;
      do_tick();
      bus.collide2 = 1'b0;
      repeat (5) do_tick();
      n_cmp++;
      if (bus.frozen !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_reset_freeze: got frz=%0b want 1", bus.frozen);
      end
      @(posedge clk);
      #3 clr = 1'b1;
      #1 test_reset();
      @(negedge clk);
      clr = 1'b0;
      set_btns(4'b0001, 4'b0000);
      do_tick();
      n_cmp++;
      if (bus.ball1_x !== 10'd302 || bus.frozen !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_play: got x1=%0d frz=%0b want 302 0", bus.ball1_x, bus.frozen);
      end
      set_btns(4'b0000, 4'b0000);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      clr = 1'b1;
      bus.prev_clk_cursor = 1'b0;
      bus.clk_cursor      = 1'b0;
      bus.collide1        = 1'b0;
      bus.collide2        = 1'b0;
      {bus.btn1_up, bus.btn1_dn, bus.btn1_lt, bus.btn1_rt} = 4'd0;
      {bus.btn2_up, bus.btn2_dn, bus.btn2_lt, bus.btn2_rt} = 4'd0;
      repeat (2) @(negedge clk);
      test_reset();
      clr = 1'b0;
      repeat (2) @(negedge clk);
      test_ramp();
      test_opposite();
      test_clamp();
      test_goal_freeze();
      test_freeze_restart();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
